// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler.
//   - opcode constants for the shared 2-bit ALU
//   - is_legal_op(): true for the five defined opcodes
//   - state_t: scheduler FSM states (ST_IDLE, ST_EXEC, ST_RESP)
package alu_sched_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Opcodes 3'b101..3'b111 are undefined.
    function automatic logic is_legal_op(input logic [2:0] opc);
        return (opc <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu2.sv
// Combinational 2-bit ALU.
// Ports:
//   a, b   in  2  operands
//   opc    in  3  opcode (add/sub/and/or/xor)
//   y      out 2  result; add/sub wrap modulo 4, undefined opcodes give 0
module alu2
    import alu_sched_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [2:0] opc,
    output logic [1:0] y
);

    always_comb begin
        y = 2'b00;
        case (opc)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Ports:
//   req      in  NREQ  request vector
//   ptr      in  IDW   highest-priority index for this search
//   gnt_vec  out NREQ  one-hot grant (zero when no request)
//   winner   out IDW   index of the granted requester
//   any_req  out 1     at least one request is set
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_vec,
    output logic [IDW-1:0]  winner,
    output logic            any_req
);

    // Walk offsets from the farthest to the nearest so that the set request
    // closest to ptr (in wrap order) is the last one written and wins.
    always_comb begin
        logic [IDW:0] cand;
        winner = '0;
        cand   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (req[cand[IDW-1:0]]) begin
                winner = cand[IDW-1:0];
            end
        end
    end

    assign any_req = |req;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign gnt_vec[gi] = any_req && (winner == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one 2-bit ALU among NREQ requesters with round-robin arbitration.
// Operands are latched at grant, executed in the next cycle, and returned
// on a valid/ready response channel tagged with the requester index.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req               per-requester level request
//   op1_flat/op2_flat operands, requester i at [2i+1:2i]
//   opc_flat          opcodes, requester i at [3i+2:3i]
//   gnt               one-hot grant pulse (combinational, IDLE only)
//   busy              high outside IDLE
//   resp_valid/ready  response handshake
//   resp_id/result/err response payload
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op1_flat,
    input  logic [2*NREQ-1:0] op2_flat,
    input  logic [3*NREQ-1:0] opc_flat,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [1:0]        resp_result,
    output logic              resp_err
);

    state_t         state_reg;
    logic [IDW-1:0] ptr_reg;
    logic [1:0]     op1_reg;
    logic [1:0]     op2_reg;
    logic [2:0]     opc_reg;
    logic [IDW-1:0] id_reg;
    logic           resp_valid_reg;
    logic [IDW-1:0] resp_id_reg;
    logic [1:0]     resp_result_reg;
    logic           resp_err_reg;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_winner;
    logic            arb_any;
    logic [IDW-1:0]  ptr_next;
    logic [1:0]      alu_y;

    logic [1:0] op1_arr [NREQ];
    logic [1:0] op2_arr [NREQ];
    logic [2:0] opc_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op1_arr[gi] = op1_flat[2*gi +: 2];
            assign op2_arr[gi] = op2_flat[2*gi +: 2];
            assign opc_arr[gi] = opc_flat[3*gi +: 3];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_reg),
        .gnt_vec (arb_gnt),
        .winner  (arb_winner),
        .any_req (arb_any)
    );

    alu2 u_alu (
        .a   (op1_reg),
        .b   (op2_reg),
        .opc (opc_reg),
        .y   (alu_y)
    );

    // Next search starts just past the winner, wrapping at NREQ-1.
    assign ptr_next = (arb_winner == IDW'(NREQ - 1)) ? '0 : arb_winner + 1'b1;

    // Grants only exist in IDLE; EXEC/RESP ignore req entirely.
    assign gnt = (state_reg == ST_IDLE) ? arb_gnt : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            ptr_reg         <= '0;
            op1_reg         <= '0;
            op2_reg         <= '0;
            opc_reg         <= '0;
            id_reg          <= '0;
            resp_valid_reg  <= 1'b0;
            resp_id_reg     <= '0;
            resp_result_reg <= '0;
            resp_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arb_any) begin
                        op1_reg   <= op1_arr[arb_winner];
                        op2_reg   <= op2_arr[arb_winner];
                        opc_reg   <= opc_arr[arb_winner];
                        id_reg    <= arb_winner;
                        ptr_reg   <= ptr_next;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_result_reg <= is_legal_op(opc_reg) ? alu_y : 2'b00;
                    resp_err_reg    <= !is_legal_op(opc_reg);
                    resp_id_reg     <= id_reg;
                    resp_valid_reg  <= 1'b1;
                    state_reg       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign resp_valid  = resp_valid_reg;
    assign resp_id     = resp_id_reg;
    assign resp_result = resp_result_reg;
    assign resp_err    = resp_err_reg;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op1_flat;
    logic [2*NREQ-1:0] op2_flat;
    logic [3*NREQ-1:0] opc_flat;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [1:0]        resp_result;
    logic              resp_err;

    int errors = 0;
    int checks = 0;

    alu_rr_scheduler #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .op1_flat    (op1_flat),
        .op2_flat    (op2_flat),
        .opc_flat    (opc_flat),
        .gnt         (gnt),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [1:0] a, input logic [1:0] b,
                          input logic [2:0] c);
        op1_flat[2*i +: 2] = a;
        op2_flat[2*i +: 2] = b;
        opc_flat[3*i +: 3] = c;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        op1_flat = '0; op2_flat = '0; opc_flat = '0;
        apply_reset();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        checks++; if ({resp_id, resp_result, resp_err} !== 5'b0) begin errors++;
            $display("FAIL reset_payload got id=%0d res=%b err=%b exp 0/00/0", resp_id, resp_result, resp_err); end
    endtask

    task automatic test_single_add();
        apply_reset();
        set_op(0, 2'b01, 2'b01, 3'b000);
        req = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        tick();
        req = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0000 || busy !== 1'b1 || resp_valid !== 1'b0) begin errors++;
            $display("FAIL single_exec got gnt=%b busy=%b valid=%b exp 0000/1/0", gnt, busy, resp_valid); end
        tick();
        $display("txn single: valid=%b id=%0d result=%b err=%b", resp_valid, resp_id, resp_result, resp_err);
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 2'b10 || resp_err !== 1'b0) begin errors++;
            $display("FAIL single_resp got v=%b id=%0d res=%b err=%b exp 1/0/10/0", resp_valid, resp_id, resp_result, resp_err); end
        tick();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL single_done got valid=%b busy=%b exp 0/0", resp_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5];
        int         exp_id  [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id  = '{0, 1, 2, 3, 0};
        apply_reset();
        set_op(0, 2'b01, 2'b10, 3'b000);   // 11
        set_op(1, 2'b11, 2'b10, 3'b010);   // 10
        set_op(2, 2'b01, 2'b10, 3'b011);   // 11
        set_op(3, 2'b11, 2'b01, 3'b100);   // 10
        req = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            checks++; if (gnt !== exp_gnt[n]) begin errors++;
                $display("FAIL rr_gnt%0d got=%b exp=%b", n, gnt, exp_gnt[n]); end
            tick();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_exec_gnt%0d got=%b exp=0000", n, gnt); end
            tick();
            $display("txn rr%0d: id=%0d result=%b err=%b", n, resp_id, resp_result, resp_err);
            checks++; if (resp_valid !== 1'b1 || resp_id !== IDW'(exp_id[n])) begin errors++;
                $display("FAIL rr_resp%0d got v=%b id=%0d exp 1/%0d", n, resp_valid, resp_id, exp_id[n]); end
            checks++; if (resp_result !== ((exp_id[n] % 2 == 0) ? 2'b11 : 2'b10)) begin errors++;
                $display("FAIL rr_result%0d got=%b", n, resp_result); end
            tick();
        end
        req = '0;
    endtask

    task automatic test_sub_skip();
        apply_reset();
        set_op(1, 2'b10, 2'b01, 3'b000);
        req = 4'b0010;
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL skip_first_gnt got=%b exp=0010", gnt); end
        tick(); req = 4'b0000; tick(); tick();
        // ptr now 2; requests 0 and 1 pending, search 2,3,0 -> 0
        set_op(0, 2'b00, 2'b01, 3'b001);
        req = 4'b0011;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL skip_gnt got=%b exp=0001", gnt); end
        tick(); req = 4'b0000; tick();
        $display("txn sub: id=%0d result=%b err=%b", resp_id, resp_result, resp_err);
        checks++; if (resp_id !== 2'd0 || resp_result !== 2'b11 || resp_err !== 1'b0) begin errors++;
            $display("FAIL sub_resp got id=%0d res=%b err=%b exp 0/11/0", resp_id, resp_result, resp_err); end
        tick();
    endtask

    task automatic test_illegal();
        apply_reset();
        set_op(3, 2'b11, 2'b11, 3'b110);
        req = 4'b1000;
        #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL ill_gnt got=%b exp=1000", gnt); end
        tick(); req = 4'b0000; tick();
        $display("txn illegal: id=%0d result=%b err=%b", resp_id, resp_result, resp_err);
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_result !== 2'b00 || resp_err !== 1'b1) begin errors++;
            $display("FAIL ill_resp got v=%b id=%0d res=%b err=%b exp 1/3/00/1", resp_valid, resp_id, resp_result, resp_err); end
        tick();
        set_op(0, 2'b11, 2'b01, 3'b000);
        req = 4'b1111;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ill_wrap_gnt got=%b exp=0001", gnt); end
        tick(); req = 4'b0000; tick();
        checks++; if (resp_result !== 2'b00 || resp_err !== 1'b0) begin errors++;
            $display("FAIL add_wrap got res=%b err=%b exp 00/0", resp_result, resp_err); end
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_op(0, 2'b10, 2'b11, 3'b100);   // 01
        req = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL bp_gnt got=%b exp=0001", gnt); end
        tick();
        req = 4'b0110;
        resp_ready = 1'b0;
        tick();
        for (int n = 0; n < 5; n++) begin
            checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 2'b01 || resp_err !== 1'b0 || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b id=%0d res=%b err=%b gnt=%b exp 1/0/01/0/0000",
                         n, resp_valid, resp_id, resp_result, resp_err, gnt);
            end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        tick();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0010) begin errors++;
            $display("FAIL bp_release got v=%b busy=%b gnt=%b exp 0/0/0010", resp_valid, busy, gnt); end
        $display("txn backpressure: next grant=%b", gnt);
        req = 4'b0000;
        #1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_op(0, 2'b01, 2'b01, 3'b000);
        req = 4'b0001;
        tick();                       // now EXEC, ptr=1
        req = 4'b0000;
        rst_n = 1'b0;
        tick();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin errors++;
            $display("FAIL rstmid got v=%b busy=%b gnt=%b exp 0/0/0000", resp_valid, busy, gnt); end
        rst_n = 1'b1;
        req = 4'b0011;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr got=%b exp=0001", gnt); end
        req = 4'b1000;
        #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rstmid_gnt got=%b exp=1000", gnt); end
        tick(); req = 4'b0000; tick();
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3) begin errors++;
            $display("FAIL rstmid_resp got v=%b id=%0d exp 1/3", resp_valid, resp_id); end
        tick();
        req = 4'b1111;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_next got=%b exp=0001", gnt); end
        req = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; resp_ready = 1'b1;
        op1_flat = '0; op2_flat = '0; opc_flat = '0;
        test_reset();
        test_single_add();
        test_round_robin();
        test_sub_skip();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
